// File: rtl/module_barrido_teclado_if.sv
// -----------------------------------------------------------------------------
// module_barrido_teclado_if
//
// Purpose: groups the keypad-side lines and the key-capture outputs of the
// 4x4 keypad scan controller into one bundle.
//
// Signals:
//   F[3:0]        raw row lines, pulled up, low = key in active column pressed
//   V             key-present flag from the row checker (asynchronous)
//   C[3:0]        column drive, active-low, exactly one bit low
//   key_code[3:0] {row_idx, col_idx} of the last accepted key
//   key_valid     one-cycle strobe when key_code updates
//   key_held      high while the accepted key remains pressed
//
// Modports:
//   master  keypad / downstream side (drives F, V; observes the rest)
//   slave   scan controller side
// -----------------------------------------------------------------------------
interface module_barrido_teclado_if;
    logic [3:0] F;
    logic       V;
    logic [3:0] C;
    logic [3:0] key_code;
    logic       key_valid;
    logic       key_held;

    modport master (
        output F, V,
        input  C, key_code, key_valid, key_held
    );

    modport slave (
        input  F, V,
        output C, key_code, key_valid, key_held
    );
endinterface

// File: rtl/module_barrido_teclado.sv
// -----------------------------------------------------------------------------
// module_barrido_teclado
//
// Purpose: scan controller for a 4x4 matrix keypad. Walks an active-low
// column drive across the four columns, watches the synchronized row lines
// and key-present flag, debounces press and release, and emits a 4-bit key
// code with a single-cycle valid strobe.
//
// Parameters:
//   SCAN_CYCLES      cycles each column stays driven while scanning (>= 4)
//   DEBOUNCE_CYCLES  consecutive stable cycles to accept press/release (>= 2)
//
// Ports:
//   clk    system clock
//   rst_n  asynchronous active-low reset
//   kp     slave modport: F, V in; C, key_code, key_valid, key_held out
// -----------------------------------------------------------------------------
module module_barrido_teclado #(
    parameter int SCAN_CYCLES     = 50000,
    parameter int DEBOUNCE_CYCLES = 500000
) (
    input  logic                     clk,
    input  logic                     rst_n,
    module_barrido_teclado_if.slave  kp
);

    localparam int DW = $clog2(SCAN_CYCLES);
    localparam int BW = $clog2(DEBOUNCE_CYCLES);

    localparam logic [DW-1:0] DWELL_LAST  = DW'(SCAN_CYCLES - 1);
    // First dwell value at which detection is allowed: two cycles of
    // synchronizer latency plus one of settling after the column switches.
    localparam logic [DW-1:0] DWELL_BLANK = DW'(3);
    localparam logic [BW-1:0] DEB_LAST    = BW'(DEBOUNCE_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_SCAN,
        ST_DEBOUNCE,
        ST_HELD,
        ST_RELEASE
    } state_e;

    // Input synchronizers
    logic [3:0] f_meta_q, f_s_q;
    logic       v_meta_q, v_s_q;

    // Control state
    state_e        state_q,     state_d;
    logic [1:0]    col_idx_q,   col_idx_d;
    logic [DW-1:0] dwell_q,     dwell_d;
    logic [BW-1:0] deb_q,       deb_d;
    logic [3:0]    pat_q,       pat_d;
    logic [3:0]    key_code_q,  key_code_d;
    logic          key_valid_q, key_valid_d;
    logic          key_held_q,  key_held_d;
    logic [3:0]    c_q;

    // Lowest row index whose line is low; several rows low -> lowest wins.
    function automatic logic [1:0] lowest_low(input logic [3:0] p);
        logic [1:0] r;
        r = 2'd0;
        for (int i = 3; i >= 0; i--) begin
            if (!p[i]) r = 2'(i);
        end
        return r;
    endfunction

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values; blocking here would create order-dependent
    // behaviour between the synchronizer stages.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // Cleared to the idle pattern (rows high, no key) so that
            // reset release never looks like a press.
            f_meta_q <= 4'b1111;
            f_s_q    <= 4'b1111;
            v_meta_q <= 1'b0;
            v_s_q    <= 1'b0;
        end else begin
            f_meta_q <= kp.F;
            f_s_q    <= f_meta_q;
            v_meta_q <= kp.V;
            v_s_q    <= v_meta_q;
        end
    end

    // NOTE: every output of this block gets a default first, so no path
    // leaves a variable unassigned and no latch is inferred.
    always_comb begin
        state_d     = state_q;
        col_idx_d   = col_idx_q;
        dwell_d     = dwell_q;
        deb_d       = deb_q;
        pat_d       = pat_q;
        key_code_d  = key_code_q;
        key_valid_d = 1'b0;
        key_held_d  = key_held_q;

        unique case (state_q)
            ST_SCAN: begin
                if (dwell_q >= DWELL_BLANK && v_s_q) begin
                    // Column stays frozen on the one that produced the hit.
                    state_d = ST_DEBOUNCE;
                    pat_d   = f_s_q;
                    deb_d   = '0;
                end else if (dwell_q == DWELL_LAST) begin
                    col_idx_d = col_idx_q + 2'd1;
                    dwell_d   = '0;
                end else begin
                    dwell_d = dwell_q + DW'(1);
                end
            end

            ST_DEBOUNCE: begin
                if (!v_s_q) begin
                    state_d = ST_SCAN;
                    dwell_d = '0;
                end else if (f_s_q != pat_q) begin
                    // Pattern moved: restart the count on the new pattern.
                    pat_d = f_s_q;
                    deb_d = '0;
                end else if (deb_q == DEB_LAST) begin
                    key_code_d  = {lowest_low(pat_q), col_idx_q};
                    key_valid_d = 1'b1;
                    key_held_d  = 1'b1;
                    state_d     = ST_HELD;
                end else begin
                    deb_d = deb_q + BW'(1);
                end
            end

            ST_HELD: begin
                if (!v_s_q) begin
                    deb_d   = '0;
                    state_d = ST_RELEASE;
                end
            end

            ST_RELEASE: begin
                if (v_s_q) begin
                    // Release bounce: key still counts as held, no strobe.
                    state_d = ST_HELD;
                end else if (deb_q == DEB_LAST) begin
                    key_held_d = 1'b0;
                    state_d    = ST_SCAN;
                    col_idx_d  = col_idx_q + 2'd1;
                    dwell_d    = '0;
                end else begin
                    deb_d = deb_q + BW'(1);
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_SCAN;
            col_idx_q   <= 2'd0;
            dwell_q     <= '0;
            deb_q       <= '0;
            pat_q       <= 4'b1111;
            key_code_q  <= 4'd0;
            key_valid_q <= 1'b0;
            key_held_q  <= 1'b0;
            c_q         <= 4'b1110;
        end else begin
            state_q     <= state_d;
            col_idx_q   <= col_idx_d;
            dwell_q     <= dwell_d;
            deb_q       <= deb_d;
            pat_q       <= pat_d;
            key_code_q  <= key_code_d;
            key_valid_q <= key_valid_d;
            key_held_q  <= key_held_d;
            // Decoded from the next column index so the drive always matches
            // col_idx_q with no extra cycle of lag.
            c_q         <= ~(4'b0001 << col_idx_d);
        end
    end

    assign kp.C         = c_q;
    assign kp.key_code  = key_code_q;
    assign kp.key_valid = key_valid_q;
    assign kp.key_held  = key_held_q;

endmodule

// File: tb/tb_module_barrido_teclado.sv
// -----------------------------------------------------------------------------
// tb_module_barrido_teclado
//
// Directed bench for the keypad scan controller with SCAN_CYCLES=8 and
// DEBOUNCE_CYCLES=16. A small keypad model turns the pressed key (row mask,
// column) and the column drive into F and V. Expected key codes are queued
// when a press is started and popped when the DUT strobes key_valid.
// -----------------------------------------------------------------------------
module tb_module_barrido_teclado;

    localparam int SCAN = 8;
    localparam int DEB  = 16;

    logic clk;
    logic rst_n;

    module_barrido_teclado_if kp ();

    module_barrido_teclado #(
        .SCAN_CYCLES    (SCAN),
        .DEBOUNCE_CYCLES(DEB)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .kp   (kp)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Keypad model: rows in press_rows go low only while press_col is driven.
    logic       pressed;
    logic [3:0] press_rows;
    logic [1:0] press_col;

    always_comb begin
        kp.F = 4'b1111;
        kp.V = 1'b0;
        if (pressed && !kp.C[press_col]) begin
            kp.F = ~press_rows;
            kp.V = 1'b1;
        end
    end

    int         vectors     = 0;
    int         miscompares = 0;
    int         strobe_cnt  = 0;
    logic       prev_valid  = 1'b0;
    logic [3:0] exp_q[$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Scoreboard side: every strobe pops one expected code.
    always @(negedge clk) begin
        if (kp.key_valid === 1'b1) begin
            strobe_cnt++;
            if (exp_q.size() > 0) check("strobe_code", 32'(kp.key_code), 32'(exp_q.pop_front()));
            else                  check("spurious_strobe", 32'(kp.key_valid), 32'd0);
            if (prev_valid) check("double_strobe", 32'(prev_valid), 32'd0);
        end
        prev_valid = kp.key_valid;
    end

    initial begin
        int t_vis;
        int cyc;
        logic seen;

        pressed    = 1'b0;
        press_rows = 4'b0000;
        press_col  = 2'd0;
        rst_n      = 1'b0;

        // ---- 1. Reset, no key ----------------------------------------------
        repeat (3) @(negedge clk);
        check("rst_C",         32'(kp.C),         32'h0000000e);
        check("rst_key_code",  32'(kp.key_code),  32'd0);
        check("rst_key_valid", 32'(kp.key_valid), 32'd0);
        check("rst_key_held",  32'(kp.key_held),  32'd0);
        rst_n = 1'b1;
        for (int k = 0; k < 5 * SCAN; k++) begin
            logic [3:0] exp_c;
            exp_c = ~(4'b0001 << ((k / SCAN) % 4));
            check("scan_C", 32'(kp.C), 32'(exp_c));
            @(negedge clk);
        end
        check("idle_strobes",  32'(strobe_cnt),  32'd0);
        check("idle_key_code", 32'(kp.key_code), 32'd0);

        // ---- 2. Press row1/col2, hold ------------------------------------------
        // C is 1101 at dwell 0 here, so V rises when C switches to 1011.
        press_rows = 4'b0010;
        press_col  = 2'd2;
        pressed    = 1'b1;
        exp_q.push_back(4'b0110);
        t_vis = -1;
        seen  = 1'b0;
        for (cyc = 0; cyc < 200; cyc++) begin
            @(negedge clk);
            if (kp.V && t_vis < 0) t_vis = cyc;
            if (kp.key_valid) begin
                seen = 1'b1;
                break;
            end
        end
        check("t2_strobe_seen", 32'(seen), 32'd1);
        // 2 sync + 3 blanking (overlapping) + 16 debounce: ~20 cycles.
        check("t2_latency_ok", 32'((cyc - t_vis) >= 18 && (cyc - t_vis) <= 24), 32'd1);
        check("t2_C_frozen",   32'(kp.C),        32'h0000000b);
        check("t2_held",       32'(kp.key_held), 32'd1);
        repeat (80) @(negedge clk);
        check("t2_C_still",    32'(kp.C),        32'h0000000b);
        check("t2_held_still", 32'(kp.key_held), 32'd1);
        check("t2_one_strobe", 32'(strobe_cnt),  32'd1);

        // ---- 4. Release with glitches, then stable release ---------------------
        for (int g = 0; g < 3; g++) begin
            pressed = 1'b0;
            repeat (6) @(negedge clk);
            check("t4_held_glitch", 32'(kp.key_held), 32'd1);
            pressed = 1'b1;
            repeat (6) @(negedge clk);
        end
        pressed = 1'b0;
        seen    = 1'b0;
        for (cyc = 1; cyc <= 60; cyc++) begin
            @(negedge clk);
            if (!kp.key_held) begin
                seen = 1'b1;
                break;
            end
        end
        check("t4_held_fell",   32'(seen), 32'd1);
        check("t4_release_len", 32'(cyc >= 17 && cyc <= 22), 32'd1);
        check("t4_C_next",      32'(kp.C),        32'h00000007);
        check("t4_code_kept",   32'(kp.key_code), 32'h00000006);
        check("t4_no_strobe",   32'(strobe_cnt),  32'd1);

        // ---- 3. Press bounce 5 on / 3 off x4 on col3 ---------------------------
        press_rows = 4'b0100;
        press_col  = 2'd3;
        for (int b = 0; b < 4; b++) begin
            pressed = 1'b1;
            repeat (5) @(negedge clk);
            pressed = 1'b0;
            repeat (3) @(negedge clk);
        end
        repeat (2) @(negedge clk);
        check("t3_same_col",  32'(kp.C),        32'h00000007);
        check("t3_not_held",  32'(kp.key_held), 32'd0);
        seen = 1'b0;
        for (cyc = 0; cyc < 20; cyc++) begin
            @(negedge clk);
            if (kp.C == 4'b1110) begin
                seen = 1'b1;
                break;
            end
        end
        check("t3_scan_resumed", 32'(seen),       32'd1);
        check("t3_no_strobe",    32'(strobe_cnt), 32'd1);

        // ---- 5. Rows 0 and 3 together on col1 ---------------------------------
        press_rows = 4'b1001;
        press_col  = 2'd1;
        pressed    = 1'b1;
        exp_q.push_back(4'b0001);
        seen = 1'b0;
        for (cyc = 0; cyc < 200; cyc++) begin
            @(negedge clk);
            if (kp.key_valid) begin
                seen = 1'b1;
                break;
            end
        end
        check("t5_strobe_seen", 32'(seen),        32'd1);
        check("t5_key_code",    32'(kp.key_code), 32'h00000001);
        check("t5_C_frozen",    32'(kp.C),        32'h0000000d);
        repeat (5) @(negedge clk);
        check("t5_one_strobe",  32'(strobe_cnt),  32'd2);
        pressed = 1'b0;
        seen    = 1'b0;
        for (cyc = 0; cyc < 60; cyc++) begin
            @(negedge clk);
            if (!kp.key_held) begin
                seen = 1'b1;
                break;
            end
        end
        check("t5_released", 32'(seen), 32'd1);
        check("t5_C_next",   32'(kp.C), 32'h0000000b);

        // ---- 6. Reset mid-DEBOUNCE (counter = 10) -----------------------------
        // C is 1011 at dwell 0, so V rises when the scan reaches col0.
        press_rows = 4'b1000;
        press_col  = 2'd0;
        pressed    = 1'b1;
        seen       = 1'b0;
        for (cyc = 0; cyc < 100; cyc++) begin
            @(negedge clk);
            if (kp.V) begin
                seen = 1'b1;
                break;
            end
        end
        check("t6_key_visible", 32'(seen), 32'd1);
        // Capture lands 4 edges after V rises; 10 more edges -> counter = 10.
        repeat (14) @(negedge clk);
        check("t6_pre_rst_held", 32'(kp.key_held), 32'd0);
        rst_n = 1'b0;
        #1;
        check("t6_rst_C",         32'(kp.C),         32'h0000000e);
        check("t6_rst_key_valid", 32'(kp.key_valid), 32'd0);
        check("t6_rst_key_held",  32'(kp.key_held),  32'd0);
        check("t6_rst_key_code",  32'(kp.key_code),  32'd0);
        pressed = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (60) @(negedge clk);
        check("t6_no_strobe", 32'(strobe_cnt),  32'd2);
        check("t6_not_held",  32'(kp.key_held), 32'd0);
        check("queue_drained", 32'(exp_q.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
